pd_loop_ctrl: RTL

//  Bang-bang loop controller for the lead/lag phase detector. Gates the detector
//  via its enable, samples lead_lag once per comparison window and steps a

---
 rtl/pd_loop_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pd_loop_ctrl.sv
// Bang-bang loop controller: gates the lead/lag phase detector, samples one decision
// per window and steps a saturating tuning code. Optional lock detection: LOCK_DET_EN.
module pd_loop_ctrl #(
  parameter int CODE_W     = 8,
  parameter int CODE_INIT  = 128,
  parameter int SETTLE_CYC = 4,
  parameter int KP         = 2,
  parameter int LOCK_CNT   = 16
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              lead_lag,
  output logic              pd_enable,
  output logic [CODE_W-1:0] dco_code,
  output logic              update,
  output logic              busy,
  output logic              locked
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_SAMPLE, S_UPDATE
  } state_t;

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CODE_W:0]   KP_W      = (CODE_W+1)'(KP);
  localparam logic [CODE_W-1:0] INIT_W    = CODE_W'(CODE_INIT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              sync_q1, sync_q2;
  logic              decision;
  logic              write_en;
  logic [CODE_W:0]   step_w;
  logic [CODE_W:0]   sum_w;
  logic [CODE_W:0]   diff_w;
  logic [CODE_W-1:0] code_nxt;

  // Handshake-free control: start/stop are levels; stop always wins and suppresses the write.
  always_comb begin
    state_nxt = state;
    pd_enable = 1'b0;
    write_en  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   if (start) state_nxt = S_ARM;
      S_ARM:    state_nxt = S_WAIT;
      S_WAIT: begin
        pd_enable = 1'b1;
        if (wait_cnt == CNT_ONE) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        pd_enable = 1'b1;
        state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        write_en  = 1'b1;
        state_nxt = S_ARM;
      end
      default:  state_nxt = S_IDLE;
    endcase
    if (stop) begin
      state_nxt = S_IDLE;
      write_en  = 1'b0;
    end
  end

`ifdef LOCK_DET_EN
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);
  localparam logic [LOCK_W-1:0] LOCK_PRE = LOCK_W'(LOCK_CNT - 1);
  localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);

  logic [LOCK_W-1:0] lock_cnt;
  logic              prev_d;

  assign step_w = locked ? (CODE_W+1)'(1) : KP_W;

  // Counter advances on each reversal; a repeated decision drops lock immediately.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      lock_cnt <= '0;
      prev_d   <= 1'b0;
      locked   <= 1'b0;
    end else if (write_en) begin
      prev_d <= decision;
      if (decision != prev_d) begin
        if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LOCK_ONE;
        if (lock_cnt >= LOCK_PRE) locked <= 1'b1;
      end else begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end
`else
  assign step_w = KP_W;
  assign locked = 1'b0;
`endif

  // d=1 means div_clk leads, so slow the oscillator; clamp at both rails.
  always_comb begin
    sum_w  = {1'b0, dco_code} + step_w;
    diff_w = {1'b0, dco_code} - step_w;
    if (decision) code_nxt = diff_w[CODE_W] ? '0 : diff_w[CODE_W-1:0];
    else          code_nxt = sum_w[CODE_W]  ? '1 : sum_w[CODE_W-1:0];
  end

  // update and the new code appear together on the edge that leaves UPDATE.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      decision <= 1'b0;
      dco_code <= INIT_W;
      update   <= 1'b0;
    end else begin
      state   <= state_nxt;
      sync_q1 <= lead_lag;
      sync_q2 <= sync_q1;
      update  <= write_en;
      if (write_en) dco_code <= code_nxt;
      if (state == S_ARM)       wait_cnt <= SETTLE_LD;
      else if (state == S_WAIT) wait_cnt <= wait_cnt - CNT_ONE;
      if (state == S_SAMPLE)    decision <= sync_q2;
    end
  end

endmodule
